tdm_demux4: RTL and testbench

- Receive-side partner of the team's 4:1 mux: rebuilds four channels from one time-division-multiplexed stream.
- Each frame is four consecutive valid beats, slot order a, b, c, d (slot index = {s1,s0} = 00, 01, 10, 11).
- A frame-sync flag marks slot a.
- Sits after the muxed link. Publishes a complete, coherent set of four channel words once per frame and detects sync loss.

---
 rtl/tdm_demux4.sv | 113 +++++++++++
 tb/tb_tdm_demux4.sv | 122 ++++++++++++
 2 files changed

// File: rtl/tdm_demux4.sv
// rtl/tdm_demux4.sv - four-slot TDM demultiplexer with frame-sync tracking
module tdm_demux4 #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic             fsync,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic [WIDTH-1:0] out_c,
    output logic [WIDTH-1:0] out_d,
    output logic             frame_valid,
    output logic             locked,
    output logic             sync_err
);

    typedef enum logic {HUNT = 1'b0, RUN = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [1:0]       slot_q, slot_d;
    logic [WIDTH-1:0] sh0, sh1, sh2;
    logic [2:0]       sh_we;
    logic             out_we;
    logic             fv_d, err_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= HUNT;
            slot_q      <= 2'd0;
            sh0         <= '0;
            sh1         <= '0;
            sh2         <= '0;
            out_a       <= '0;
            out_b       <= '0;
            out_c       <= '0;
            out_d       <= '0;
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            frame_valid <= fv_d;
            sync_err    <= err_d;
            if (sh_we[0]) sh0 <= din;
            if (sh_we[1]) sh1 <= din;
            if (sh_we[2]) sh2 <= din;
            // Publish all four words on one edge so consumers never see a mixed frame
            if (out_we) begin
                out_a <= sh0;
                out_b <= sh1;
                out_c <= sh2;
                out_d <= din;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        sh_we   = 3'b000;
        out_we  = 1'b0;
        fv_d    = 1'b0;
        err_d   = 1'b0;
        if (din_valid) begin
            case (state_q)
                HUNT: begin
                    if (fsync) begin
                        sh_we[0] = 1'b1;
                        slot_d   = 2'd1;
                        state_d  = RUN;
                    end
                end
                RUN: begin
                    if (fsync) begin
                        // An early sync restarts the frame on this beat
                        err_d    = (slot_q != 2'd0);
                        sh_we[0] = 1'b1;
                        slot_d   = 2'd1;
                    end else begin
                        case (slot_q)
                            2'd0: begin
                                err_d   = 1'b1;
                                state_d = HUNT;
                                slot_d  = 2'd0;
                            end
                            2'd1: begin
                                sh_we[1] = 1'b1;
                                slot_d   = 2'd2;
                            end
                            2'd2: begin
                                sh_we[2] = 1'b1;
                                slot_d   = 2'd3;
                            end
                            default: begin
                                out_we = 1'b1;
                                fv_d   = 1'b1;
                                slot_d = 2'd0;
                            end
                        endcase
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_comb begin
        locked = (state_q == RUN);
    end

endmodule

// File: tb/tb_tdm_demux4.sv
// tb/tb_tdm_demux4.sv - directed self-checking bench for tdm_demux4
module tb_tdm_demux4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] din = 2'd0;
    logic       din_valid = 1'b0;
    logic       fsync = 1'b0;
    logic [1:0] out_a, out_b, out_c, out_d;
    logic       frame_valid, locked, sync_err;

    int vectors = 0;
    int miscompares = 0;

    tdm_demux4 #(.WIDTH(2)) dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .fsync(fsync),
        .out_a(out_a), .out_b(out_b), .out_c(out_c), .out_d(out_d),
        .frame_valid(frame_valid), .locked(locked), .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    task automatic step(input logic r, input logic v, input logic fs, input logic [1:0] d);
        @(negedge clk);
        rst = r; din_valid = v; fsync = fs; din = d;
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic fs, input logic [1:0] d);
        step(1'b0, 1'b1, fs, d);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 2'd0);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // flags packed as {frame_valid, locked, sync_err}
    task automatic chk_flags(input string tag, input logic [2:0] exp);
        chk(tag, {29'd0, frame_valid, locked, sync_err}, {29'd0, exp});
    endtask

    task automatic chk_outs(input string tag, input logic [7:0] exp);
        chk(tag, {24'd0, out_a, out_b, out_c, out_d}, {24'd0, exp});
    endtask

    initial begin
        step(1'b1, 1'b0, 1'b0, 2'd0);
        step(1'b1, 1'b1, 1'b1, 2'd3);
        chk_flags("reset_flags", 3'b000);
        chk_outs("reset_outs", 8'h00);

        beat(1'b1, 2'd0);  chk_flags("f1_a", 3'b010);
        beat(1'b0, 2'd1);  chk_flags("f1_b", 3'b010);
        beat(1'b0, 2'd2);  chk_flags("f1_c", 3'b010);
        chk_outs("f1_hold", 8'h00);
        beat(1'b0, 2'd3);  chk_flags("f1_d", 3'b110);
        chk_outs("f1_outs", 8'h1B);
        idle();            chk_flags("f1_after", 3'b010);
        chk_outs("f1_keep", 8'h1B);

        beat(1'b1, 2'd0);  idle();
        beat(1'b0, 2'd1);  idle(); idle();
        chk_flags("stall_mid", 3'b010);
        beat(1'b0, 2'd2);  idle(); idle(); idle();
        chk_flags("stall_gap", 3'b010);
        beat(1'b0, 2'd3);  chk_flags("stall_d", 3'b110);
        chk_outs("stall_outs", 8'h1B);
        idle();            chk_flags("stall_after", 3'b010);

        beat(1'b1, 2'd3);
        beat(1'b0, 2'd2);
        beat(1'b1, 2'd1);  chk_flags("early_err", 3'b011);
        chk_outs("early_hold", 8'h1B);
        beat(1'b0, 2'd0);  chk_flags("early_b", 3'b010);
        beat(1'b0, 2'd3);  chk_flags("early_c", 3'b010);
        beat(1'b0, 2'd2);  chk_flags("early_d", 3'b110);
        chk_outs("early_outs", 8'h4E);

        beat(1'b0, 2'd2);  chk_flags("miss_err", 3'b001);
        chk_outs("miss_hold", 8'h4E);
        beat(1'b0, 2'd1);  chk_flags("miss_ign1", 3'b000);
        beat(1'b0, 2'd3);  chk_flags("miss_ign2", 3'b000);
        beat(1'b1, 2'd3);  chk_flags("relock_a", 3'b010);
        beat(1'b0, 2'd2);
        beat(1'b0, 2'd1);
        beat(1'b0, 2'd0);  chk_flags("relock_d", 3'b110);
        chk_outs("relock_outs", 8'hE4);

        beat(1'b1, 2'd0);  chk_flags("b2b_1a", 3'b010);
        beat(1'b0, 2'd1);
        beat(1'b0, 2'd2);
        beat(1'b0, 2'd3);  chk_flags("b2b_1d", 3'b110);
        chk_outs("b2b_1outs", 8'h1B);
        beat(1'b1, 2'd3);  chk_flags("b2b_2a", 3'b010);
        beat(1'b0, 2'd2);  chk_flags("b2b_2b", 3'b010);
        beat(1'b0, 2'd1);  chk_flags("b2b_2c", 3'b010);
        beat(1'b0, 2'd0);  chk_flags("b2b_2d", 3'b110);
        chk_outs("b2b_2outs", 8'hE4);

        beat(1'b1, 2'd1);
        beat(1'b0, 2'd2);
        step(1'b1, 1'b1, 1'b0, 2'd3);
        chk_flags("midrst_flags", 3'b000);
        chk_outs("midrst_outs", 8'h00);
        beat(1'b0, 2'd3);  chk_flags("midrst_ign1", 3'b000);
        beat(1'b0, 2'd0);  chk_flags("midrst_ign2", 3'b000);
        chk_outs("midrst_keep", 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
